down_counter_expiry_monitor: RTL and testbench

//  Downstream consumer of the free-running N-bit down counter. Detects terminal count
//  (value reaching 0) and turns it into a registered one-cycle tick. Runs an arm/expire
//  FSM with a valid/ack handshake toward the next stage, plus a saturating expiry tally
//  and a sticky overrun flag for expiries lost while the previous one was unacknowledged.

---
 rtl/down_counter_expiry_monitor_if.sv | 35 +++
 rtl/down_counter_expiry_monitor.sv | 138 +++++++++++++
 tb/tb_down_counter_expiry_monitor.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/down_counter_expiry_monitor_if.sv
// Signal bundle between the down-counter stage, the expiry monitor and its consumer.
// seq_err exists only when DOWN_COUNTER_EXPIRY_MONITOR_SEQCHK_EN is defined.
interface down_counter_expiry_monitor_if #(
   parameter int N  = 10,
   parameter int CW = 8
);
   logic [N-1:0]  down_counter;
   logic          arm;
   logic          ack;
   logic          tc_pulse;
   logic          expired_valid;
   logic [CW-1:0] expire_count;
   logic          overrun;
`ifdef DOWN_COUNTER_EXPIRY_MONITOR_SEQCHK_EN
   logic          seq_err;

   modport master (
      output down_counter, arm, ack,
      input  tc_pulse, expired_valid, expire_count, overrun, seq_err
   );
   modport slave (
      input  down_counter, arm, ack,
      output tc_pulse, expired_valid, expire_count, overrun, seq_err
   );
`else
   modport master (
      output down_counter, arm, ack,
      input  tc_pulse, expired_valid, expire_count, overrun
   );
   modport slave (
      input  down_counter, arm, ack,
      output tc_pulse, expired_valid, expire_count, overrun
   );
`endif
endinterface

// File: rtl/down_counter_expiry_monitor.sv
// Terminal-count tick, arm/expire handshake FSM, saturating expiry tally and sticky overrun.
// Optional step checker on the counter value: DOWN_COUNTER_EXPIRY_MONITOR_SEQCHK_EN.
module down_counter_expiry_monitor #(
   parameter int N          = 10,
   parameter int CW         = 8,
   parameter bit AUTO_REARM = 1'b0
) (
   input  logic                          clk,
   input  logic                          reset,
   down_counter_expiry_monitor_if.slave  mon
);
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_EXPIRED = 2'd2
   } state_t;

   localparam logic [CW-1:0] COUNT_MAX = {CW{1'b1}};
   localparam logic [CW-1:0] COUNT_ONE = {{(CW-1){1'b0}}, 1'b1};

   state_t        state_r, state_nxt_s;
   logic          zero_r;
   logic          tc_pulse_r;
   logic          valid_r, valid_nxt_s;
   logic [CW-1:0] count_r, count_nxt_s;
   logic          overrun_r, overrun_nxt_s;
   logic          is_zero_s;
   logic          tc_ev_s;
   logic          count_inc_s;

   // zero_r starts at 1 because the counter reads 0 during reset; no tick on release.
   assign is_zero_s = (mon.down_counter == {N{1'b0}});
   assign tc_ev_s   = is_zero_s & ~zero_r;

   // State and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         zero_r     <= 1'b1;
         tc_pulse_r <= 1'b0;
         valid_r    <= 1'b0;
         count_r    <= {CW{1'b0}};
         overrun_r  <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         zero_r     <= is_zero_s;
         tc_pulse_r <= tc_ev_s;
         valid_r    <= valid_nxt_s;
         count_r    <= count_nxt_s;
         overrun_r  <= overrun_nxt_s;
      end
   end

   // Next state, handshake flags and tally
   always_comb begin
      state_nxt_s   = state_r;
      valid_nxt_s   = valid_r;
      overrun_nxt_s = overrun_r;
      count_inc_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            valid_nxt_s = 1'b0;
            if (mon.arm) begin
               state_nxt_s = ST_ARMED;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ARMED: begin
            if (tc_ev_s) begin
               state_nxt_s = ST_EXPIRED;
               valid_nxt_s = 1'b1;
               count_inc_s = 1'b1;
            end else if (!mon.arm) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_ARMED;
            end
         end
         ST_EXPIRED: begin
            // A new expiry with ack replaces the acknowledged one; without ack it is an overrun.
            if (tc_ev_s) begin
               count_inc_s   = 1'b1;
               overrun_nxt_s = ~mon.ack;
            end else if (mon.ack) begin
               valid_nxt_s   = 1'b0;
               overrun_nxt_s = 1'b0;
               state_nxt_s   = AUTO_REARM ? ST_ARMED : ST_IDLE;
            end else begin
               state_nxt_s = ST_EXPIRED;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            valid_nxt_s = 1'b0;
         end
      endcase

      if (count_inc_s && (count_r != COUNT_MAX)) begin
         count_nxt_s = count_r + COUNT_ONE;
      end else begin
         count_nxt_s = count_r;
      end
   end

   assign mon.tc_pulse      = tc_pulse_r;
   assign mon.expired_valid = valid_r;
   assign mon.expire_count  = count_r;
   assign mon.overrun       = overrun_r;

`ifdef DOWN_COUNTER_EXPIRY_MONITOR_SEQCHK_EN
   localparam logic [N-1:0] STEP_ONE = {{(N-1){1'b0}}, 1'b1};

   logic [N-1:0] prev_r;
   logic         seq_live_r;
   logic         seq_err_r;
   logic         step_ok_s;

   // Modular decrement also covers the 0 -> 2^N-1 wrap.
   assign step_ok_s = (mon.down_counter == prev_r) ||
                      (mon.down_counter == (prev_r - STEP_ONE));

   // Sticky step checker; the first edge after reset only captures the value
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_r     <= {N{1'b0}};
         seq_live_r <= 1'b0;
         seq_err_r  <= 1'b0;
      end else begin
         prev_r     <= mon.down_counter;
         seq_live_r <= 1'b1;
         seq_err_r  <= seq_err_r | (seq_live_r & ~step_ok_s);
      end
   end

   assign mon.seq_err = seq_err_r;
`endif
endmodule

// File: tb/tb_down_counter_expiry_monitor.sv
// Self-checking bench for down_counter_expiry_monitor: directed scenarios plus random
// stimulus, compared every cycle against a behavioural model of the expiry rules.
module tb_down_counter_expiry_monitor;
   localparam int N          = 10;
   localparam int CW         = 8;
   localparam bit AUTO_REARM = 1'b0;
   localparam int CMAX       = (1 << CW) - 1;
   localparam int MODN       = 1 << N;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   down_counter_expiry_monitor_if #(.N(N), .CW(CW)) bus ();

   down_counter_expiry_monitor #(.N(N), .CW(CW), .AUTO_REARM(AUTO_REARM)) dut (
      .clk   (clk),
      .reset (reset),
      .mon   (bus)
   );

   always #5 clk = ~clk;

   // Behavioural model: one pending expiry at most, plus an "armed" permission flag.
   bit m_zero_seen, m_armed, m_pending, m_overrun, m_tick;
   int m_count;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_zero_seen = 1'b1;
      m_armed     = 1'b0;
      m_pending   = 1'b0;
      m_overrun   = 1'b0;
      m_tick      = 1'b0;
      m_count     = 0;
   endtask

   task automatic model_edge(input int dc, input bit a, input bit k);
      bit tc;
      tc          = (dc == 0) && !m_zero_seen;
      m_zero_seen = (dc == 0);
      m_tick      = tc;
      if (m_pending) begin
         if (tc) begin
            m_count   = (m_count < CMAX) ? m_count + 1 : CMAX;
            m_overrun = !k;
         end else if (k) begin
            m_pending = 1'b0;
            m_overrun = 1'b0;
            m_armed   = AUTO_REARM;
         end
      end else if (m_armed) begin
         if (tc) begin
            m_pending = 1'b1;
            m_count   = (m_count < CMAX) ? m_count + 1 : CMAX;
         end else if (!a) begin
            m_armed = 1'b0;
         end
      end else if (a) begin
         m_armed = 1'b1;
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".tc_pulse"}, 32'(bus.tc_pulse),      32'(m_tick));
      check({tag, ".valid"},    32'(bus.expired_valid), 32'(m_pending));
      check({tag, ".count"},    32'(bus.expire_count),  32'(m_count));
      check({tag, ".overrun"},  32'(bus.overrun),       32'(m_overrun));
   endtask

   task automatic step(input int dc, input bit a, input bit k, input string tag);
      bus.down_counter = dc[N-1:0];
      bus.arm          = a;
      bus.ack          = k;
      @(posedge clk);
      model_edge(dc, a, k);
      #1;
      check_all(tag);
   endtask

   task automatic random_phase(input int cycles);
      int r, dc;
      for (int i = 0; i < cycles; i++) begin
         r = int'($urandom_range(0, 3));
         dc = (r == 3) ? int'($urandom_range(0, MODN - 1)) : r;
         step(dc, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0), "rand");
      end
   endtask

   task automatic release_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      int cnt;
      int first_tick;

      bus.down_counter = '0;
      bus.arm          = 1'b0;
      bus.ack          = 1'b0;
      model_reset();

      // 1: reset held ~1000 ns with the counter at 0
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         check("rst_tc_pulse", 32'(bus.tc_pulse), 32'd0);
      end
      check_all("rst_state");
      release_reset();

      // 1-3: full counter stage; arm high through the second zero, ack once after it
      cnt = 0;
      first_tick = -1;
      for (int k = 0; k <= 3 * MODN; k++) begin
         step(cnt, (k <= 2 * MODN), (k == 2 * MODN + 1), "cnt");
         if (bus.tc_pulse && first_tick < 0) first_tick = k;
         if (k == MODN) begin
            check("t2_valid", 32'(bus.expired_valid), 32'd1);
            check("t2_count1", 32'(bus.expire_count), 32'd1);
         end
         if (k == MODN + 1) check("t1_width", 32'(bus.tc_pulse), 32'd0);
         if (k == 2 * MODN) begin
            check("t2_overrun", 32'(bus.overrun), 32'd1);
            check("t2_count2", 32'(bus.expire_count), 32'd2);
         end
         if (k == 2 * MODN + 1) begin
            check("t3_valid", 32'(bus.expired_valid), 32'd0);
            check("t3_overrun", 32'(bus.overrun), 32'd0);
         end
         if (k == 3 * MODN) begin
            check("t3_tick_idle", 32'(bus.tc_pulse), 32'd1);
            check("t3_count_hold", 32'(bus.expire_count), 32'd2);
         end
         cnt = (cnt + MODN - 1) % MODN;
      end
      check("t1_first_tick", 32'(first_tick), 32'(MODN));

      // 4: overrun, then ack coinciding with a new expiry
      step(1, 1'b1, 1'b0, "t4");
      step(0, 1'b1, 1'b0, "t4");
      check("t4_count3", 32'(bus.expire_count), 32'd3);
      step(1, 1'b0, 1'b0, "t4");
      step(0, 1'b0, 1'b0, "t4");
      check("t4_overrun", 32'(bus.overrun), 32'd1);
      step(1, 1'b0, 1'b0, "t4");
      step(0, 1'b0, 1'b1, "t4");
      check("t4_valid", 32'(bus.expired_valid), 32'd1);
      check("t4_count5", 32'(bus.expire_count), 32'd5);
      check("t4_ovr_clr", 32'(bus.overrun), 32'd0);

      random_phase(1500);

      // 5: saturate the tally with acknowledged back-to-back expiries
      step(1, 1'b1, 1'b0, "t5");
      step(1, 1'b1, 1'b0, "t5");
      step(0, 1'b1, 1'b0, "t5");
      for (int i = 0; i < 300; i++) begin
         step(1, 1'b0, 1'b0, "t5");
         step(0, 1'b0, 1'b1, "t5");
      end
      check("t5_sat", 32'(bus.expire_count), 32'(CMAX));
      check("t5_valid", 32'(bus.expired_valid), 32'd1);

      // 5: asynchronous reset in the middle of a cycle while EXPIRED
      #3;
      reset = 1'b1;
      bus.down_counter = '0;
      model_reset();
      #1;
      check_all("t5_async_rst");
      repeat (3) @(posedge clk);
      release_reset();
      random_phase(500);

`ifdef DOWN_COUNTER_EXPIRY_MONITOR_SEQCHK_EN
      // 6: illegal step 5 -> 7, then legal wrap 0 -> 1023 -> 1022
      reset = 1'b1;
      bus.down_counter = 10'd5;
      repeat (2) @(posedge clk);
      check("t6_rst", 32'(bus.seq_err), 32'd0);
      #1 reset = 1'b0;
      @(posedge clk);
      #1 bus.down_counter = 10'd7;
      @(posedge clk);
      #1 check("t6_bad_step", 32'(bus.seq_err), 32'd1);
      reset = 1'b1;
      bus.down_counter = 10'd0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk);
      #1 bus.down_counter = 10'd1023;
      @(posedge clk);
      #1 bus.down_counter = 10'd1022;
      @(posedge clk);
      #1 check("t6_wrap_ok", 32'(bus.seq_err), 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
